t02_writeback_unit: RTL and testbench
=====================================

Name: t02_writeback_unit

Overview:
- Writer side of t02_register_file: gathers results from the execute stage and the data-memory load path.
- Drives the register file's reg_write / write_index / write_data port with registered, single-cycle write pulses.
- Owns the multi-cycle load handshake with data memory: extracts byte lanes, sign/zero-extends, and stalls the pipeline while a load is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in LOAD_WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- nRST  in  1  synchronous, active-high reset; 1 resets on the next clk edge.
- en  in  1  pipeline advance; wb_valid is sampled only when en=1.
- wb_valid  in  1  writeback request present this cycle.
- wb_rd  in  5  destination register index.
- wb_sel  in  2  result source: ALU=0, LOAD=1, PC4=2, IMM=3.
- wb_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- alu_result  in  32  ALU result; also the load address when wb_sel=LOAD.
- pc_plus4  in  32  link value.
- imm  in  32  immediate (LUI path).
- mem_req  out  1  load request to data memory, held until ack.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_ack  in  1  memory response valid, 1 cycle.
- mem_rdata  in  32  memory read word, valid with mem_ack.
- rf_we  out  1  register-file write strobe (to reg_write).
- rf_windex  out  5  register-file write index.
- rf_wdata  out  32  register-file write data.
- stall  out  1  pipeline hold while a load is outstanding.
- misalign_err  out  1  1-cycle pulse on a misaligned load.

Behaviour:
- Reset: all outputs 0; state IDLE; captured rd/funct3/addr registers cleared.
- States: IDLE, LOAD_WAIT.
- IDLE, en & wb_valid & wb_sel!=LOAD:
  - Next cycle: rf_we=(wb_rd!=0), rf_windex=wb_rd, rf_wdata=selected source. Latency is 1 cycle.
  - Stay in IDLE.
- IDLE, en & wb_valid & wb_sel=LOAD, aligned:
  - Capture rd, funct3 and addr[1:0].
  - Next cycle: mem_req=1, mem_addr=aligned addr, stall=1; go to LOAD_WAIT.
  - Back-to-back issue is allowed: rf_we of a previous non-load still pulses in that same cycle.
- Alignment rule: misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - Next cycle: misalign_err=1 for 1 cycle; no mem_req, no write; stay in IDLE.
  - Unlisted funct3 codes are treated as LW.
- LOAD_WAIT:
  - mem_req, mem_addr and stall are held constant.
  - wb_valid is ignored; upstream must honour stall.
- LOAD_WAIT, mem_ack=1:
  - Next cycle: rf_we=(rd!=0), rf_wdata=formatted data, mem_req=0, stall=0; go to IDLE.
  - Load-to-write latency is 1 cycle after ack.
- Data formatting:
  - Byte lane = addr[1:0]*8; halfword lane = addr[1]*16.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- rd=0: the load still completes the memory handshake but rf_we stays 0. The register file is never written at index 0.
- rf_we is a single-cycle pulse; it is never asserted two cycles running for one request.
- en=0 in IDLE: no capture; outputs return to 0 on the next cycle.
- nRST mid-LOAD_WAIT:
  - Go to IDLE; mem_req=0, stall=0.
  - A late mem_ack arriving in IDLE is ignored.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to LOAD_WAIT and increments each cycle without ack.
  - At count == TIMEOUT_CYCLES-1 with no ack: abort. Next cycle: mem_req=0, stall=0, no write, misalign_err pulses 1 cycle (shared error strobe), state IDLE.
  - An ack in the same cycle as the limit wins: a normal write occurs.
- Undefined: no counter logic; LOAD_WAIT waits indefinitely.

Decomposition:
- Package t02_wb_pkg:
  - wb_sel_t enum (ALU, LOAD, PC4, IMM).
  - wb_state_t enum (IDLE, LOAD_WAIT).
  - funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
- Sub-module t02_load_formatter: combinational; inputs funct3, addr[1:0], rdata; outputs 32-bit extended data. The FSM, registers and mux stay in the top.

Test Plan:
- ALU write: en=1, wb_valid=1, wb_sel=ALU, wb_rd=5, alu_result=0x0000_1234 -> next cycle rf_we=1, rf_windex=5, rf_wdata=0x0000_1234; following cycle rf_we=0.
- LB sign: LOAD, funct3=LB, addr=0x103, rd=7; ack after 3 cycles with rdata=0x80FF_0000 -> mem_addr=0x100, stall=1 for 4 cycles, then rf_wdata=0xFFFF_FF80, rf_we=1.
- LHU/rd0: LOAD, funct3=LHU, addr=0x202, rdata=0xBEEF_0000 with rd=3 -> rf_wdata=0x0000_BEEF. Same with rd=0 -> handshake completes, rf_we stays 0.
- Misaligned: LOAD, funct3=LW, addr=0x101 -> misalign_err=1 one cycle, mem_req never rises, rf_we=0.
- Reset mid-load: assert nRST during LOAD_WAIT, then ack 2 cycles later -> mem_req=0, stall=0 after the edge; no rf_we from the late ack.
- WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4: no ack -> after 4 wait cycles mem_req=0, stall=0, misalign_err pulses, rf_we=0.

Source files
------------

// File: rtl/t02_wb_pkg.sv
// ---------------------------------------------------------------------------
// t02_wb_pkg
// Shared types and constants for the writeback unit of t02_register_file.
//   wb_sel_t     : result source select (ALU, LOAD, PC4, IMM)
//   wb_state_t   : writeback FSM states (IDLE, LOAD_WAIT)
//   F3_*         : load funct3 encodings
//   is_misaligned: alignment rule for a load of a given funct3/address
// ---------------------------------------------------------------------------
package t02_wb_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_PC4  = 2'd2,
        SEL_IMM  = 2'd3
    } wb_sel_t;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte loads can never be misaligned, halfwords need addr[0]=0, and
    // everything else (including unlisted codes) is handled as a word load.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] addrLo);
        logic mis;
        case (f3)
            F3_LB, F3_LBU: mis = 1'b0;
            F3_LH, F3_LHU: mis = addrLo[0];
            default:       mis = (addrLo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/t02_load_formatter.sv
// ---------------------------------------------------------------------------
// t02_load_formatter
// Combinational byte-lane extraction and sign/zero extension of a load word.
//   i_funct3  : load type (LB/LH/LW/LBU/LHU; unlisted codes behave as LW)
//   i_addr_lo : low two bits of the load address (selects the lane)
//   i_rdata   : raw 32-bit word returned by data memory
//   o_data    : value to write into the register file
// ---------------------------------------------------------------------------
module t02_load_formatter
    import t02_wb_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection: byte lane is addr[1:0]*8, halfword lane is addr[1]*16.
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extension according to the load type.
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'h000000, w_byte};
            F3_LHU:  o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/t02_writeback_unit.sv
// ---------------------------------------------------------------------------
// t02_writeback_unit
// Writer side of t02_register_file. Collects execute-stage results and load
// data, and issues registered single-cycle writes to the register file.
// Loads are handled with a request/ack handshake to data memory during which
// the pipeline is stalled.
//
// Optional build macro: WB_LOAD_TIMEOUT_EN
//   When defined, a load that sees no ack for TIMEOUT_CYCLES wait cycles is
//   aborted and reported on o_misalign_err (shared error strobe).
//
// Ports
//   i_clk, i_nRST          : clock, synchronous active-high reset
//   i_en, i_wb_valid       : pipeline advance / writeback request
//   i_wb_rd, i_wb_sel      : destination index / result source
//   i_wb_funct3            : load type
//   i_alu_result           : ALU result, also the load address
//   i_pc_plus4, i_imm      : link value / immediate
//   o_mem_req, o_mem_addr  : load request and word-aligned address
//   i_mem_ack, i_mem_rdata : memory response
//   o_rf_we, o_rf_windex,
//   o_rf_wdata             : register-file write port
//   o_stall                : pipeline hold while a load is outstanding
//   o_misalign_err         : one-cycle error pulse
// ---------------------------------------------------------------------------
module t02_writeback_unit
    import t02_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        i_clk,
    input  logic        i_nRST,
    input  logic        i_en,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [1:0]  i_wb_sel,
    input  logic [2:0]  i_wb_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_imm,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_windex,
    output logic [31:0] o_rf_wdata,
    output logic        o_stall,
    output logic        o_misalign_err
);

    wb_state_t   r_state, w_state_next;

    logic [4:0]  r_rd,      w_rd_next;
    logic [2:0]  r_funct3,  w_funct3_next;
    logic [1:0]  r_addr_lo, w_addr_lo_next;

    logic        r_mem_req,   w_mem_req_next;
    logic [31:0] r_mem_addr,  w_mem_addr_next;
    logic        r_stall,     w_stall_next;
    logic        r_rf_we,     w_rf_we_next;
    logic [4:0]  r_rf_windex, w_rf_windex_next;
    logic [31:0] r_rf_wdata,  w_rf_wdata_next;
    logic        r_misalign,  w_misalign_next;

    wb_sel_t     w_sel;
    logic [31:0] w_src_data;
    logic [31:0] w_load_data;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_count, w_count_next;
`else
    // Without the timeout the limit has no effect; it is referenced here so
    // the parameter remains part of the interface in both builds.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    assign w_sel = wb_sel_t'(i_wb_sel);

    // Result source for non-load writebacks.
    always_comb begin
        w_src_data = i_alu_result;
        case (w_sel)
            SEL_PC4: w_src_data = i_pc_plus4;
            SEL_IMM: w_src_data = i_imm;
            default: w_src_data = i_alu_result;
        endcase
    end

    // Load data is formatted from the captured funct3/lane, not the live
    // inputs, because upstream may already have moved on during LOAD_WAIT.
    t02_load_formatter u_formatter (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (i_mem_rdata),
        .o_data    (w_load_data)
    );

    // Next-state and next-output logic. Every output defaults to 0 so that
    // write and error strobes are single-cycle pulses; only the handshake
    // outputs are explicitly held while waiting for memory.
    always_comb begin
        w_state_next     = r_state;
        w_rd_next        = r_rd;
        w_funct3_next    = r_funct3;
        w_addr_lo_next   = r_addr_lo;
        w_mem_req_next   = 1'b0;
        w_mem_addr_next  = 32'h0;
        w_stall_next     = 1'b0;
        w_rf_we_next     = 1'b0;
        w_rf_windex_next = 5'd0;
        w_rf_wdata_next  = 32'h0;
        w_misalign_next  = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
        w_count_next     = r_count;
`endif

        case (r_state)
            IDLE: begin
                if (i_en && i_wb_valid) begin
                    if (w_sel == SEL_LOAD) begin
                        if (is_misaligned(i_wb_funct3, i_alu_result[1:0])) begin
                            w_misalign_next = 1'b1;
                        end else begin
                            w_rd_next       = i_wb_rd;
                            w_funct3_next   = i_wb_funct3;
                            w_addr_lo_next  = i_alu_result[1:0];
                            w_mem_req_next  = 1'b1;
                            w_mem_addr_next = {i_alu_result[31:2], 2'b00};
                            w_stall_next    = 1'b1;
                            w_state_next    = LOAD_WAIT;
`ifdef WB_LOAD_TIMEOUT_EN
                            w_count_next    = '0;
`endif
                        end
                    end else begin
                        w_rf_we_next     = (i_wb_rd != 5'd0);
                        w_rf_windex_next = i_wb_rd;
                        w_rf_wdata_next  = w_src_data;
                    end
                end
            end

            LOAD_WAIT: begin
                w_mem_req_next  = 1'b1;
                w_mem_addr_next = r_mem_addr;
                w_stall_next    = 1'b1;
                if (i_mem_ack) begin
                    // An ack on the timeout limit cycle still completes.
                    w_mem_req_next   = 1'b0;
                    w_mem_addr_next  = 32'h0;
                    w_stall_next     = 1'b0;
                    w_rf_we_next     = (r_rd != 5'd0);
                    w_rf_windex_next = r_rd;
                    w_rf_wdata_next  = w_load_data;
                    w_state_next     = IDLE;
                end
`ifdef WB_LOAD_TIMEOUT_EN
                else if (r_count == CNT_LIMIT) begin
                    w_mem_req_next  = 1'b0;
                    w_mem_addr_next = 32'h0;
                    w_stall_next    = 1'b0;
                    w_misalign_next = 1'b1;
                    w_state_next    = IDLE;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
`endif
            end

            default: w_state_next = IDLE;
        endcase
    end

    // State and output registers; synchronous reset clears everything, which
    // also drops an outstanding load so a late ack lands in IDLE unused.
    always_ff @(posedge i_clk) begin
        if (i_nRST) begin
            r_state     <= IDLE;
            r_rd        <= 5'd0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_stall     <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_windex <= 5'd0;
            r_rf_wdata  <= 32'h0;
            r_misalign  <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
            r_count     <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_rd        <= w_rd_next;
            r_funct3    <= w_funct3_next;
            r_addr_lo   <= w_addr_lo_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_addr  <= w_mem_addr_next;
            r_stall     <= w_stall_next;
            r_rf_we     <= w_rf_we_next;
            r_rf_windex <= w_rf_windex_next;
            r_rf_wdata  <= w_rf_wdata_next;
            r_misalign  <= w_misalign_next;
`ifdef WB_LOAD_TIMEOUT_EN
            r_count     <= w_count_next;
`endif
        end
    end

    assign o_mem_req      = r_mem_req;
    assign o_mem_addr     = r_mem_addr;
    assign o_stall        = r_stall;
    assign o_rf_we        = r_rf_we;
    assign o_rf_windex    = r_rf_windex;
    assign o_rf_wdata     = r_rf_wdata;
    assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_t02_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_t02_writeback_unit
// Directed bench for t02_writeback_unit: single-cycle vectors from a table,
// plus hand-written load handshake, back-to-back, reset and timeout sequences.
// Build with WB_LOAD_TIMEOUT_EN to exercise the timeout (limit set to 4).
// ---------------------------------------------------------------------------
module tb_t02_writeback_unit;

    logic        clk = 1'b0;
    logic        nRST;
    logic        en;
    logic        wbValid;
    logic [4:0]  wbRd;
    logic [1:0]  wbSel;
    logic [2:0]  wbFunct3;
    logic [31:0] aluResult;
    logic [31:0] pcPlus4;
    logic [31:0] immVal;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;
    logic        rfWe;
    logic [4:0]  rfWindex;
    logic [31:0] rfWdata;
    logic        stall;
    logic        misalignErr;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        string       name;
        logic        en;
        logic        valid;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        expWe;
        logic [4:0]  expIdx;
        logic [31:0] expData;
        logic        expMis;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    t02_writeback_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .i_clk          (clk),
        .i_nRST         (nRST),
        .i_en           (en),
        .i_wb_valid     (wbValid),
        .i_wb_rd        (wbRd),
        .i_wb_sel       (wbSel),
        .i_wb_funct3    (wbFunct3),
        .i_alu_result   (aluResult),
        .i_pc_plus4     (pcPlus4),
        .i_imm          (immVal),
        .o_mem_req      (memReq),
        .o_mem_addr     (memAddr),
        .i_mem_ack      (memAck),
        .i_mem_rdata    (memRdata),
        .o_rf_we        (rfWe),
        .o_rf_windex    (rfWindex),
        .o_rf_wdata     (rfWdata),
        .o_stall        (stall),
        .o_misalign_err (misalignErr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [4:0] rd,
                                 input logic [1:0] sel, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] pc4,
                                 input logic [31:0] imm);
        en        = e;
        wbValid   = v;
        wbRd      = rd;
        wbSel     = sel;
        wbFunct3  = f3;
        aluResult = alu;
        pcPlus4   = pc4;
        immVal    = imm;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue a load, wait ackDelay extra cycles, ack, and check the write.
    task automatic runLoad(input string name, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [4:0] rd,
                           input int ackDelay, input logic [31:0] rdata,
                           input logic expWe, input logic [31:0] expData);
        int stallCycles = 0;
        applyStimulus(1'b1, 1'b1, rd, 2'd1, f3, addr, 32'h0, 32'h0);
        nextCycle();
        idleInputs();
        checkOutput({name, " mem_req"}, {31'b0, memReq}, 32'd1);
        checkOutput({name, " mem_addr"}, memAddr, {addr[31:2], 2'b00});
        if (stall) stallCycles++;
        for (int i = 0; i < ackDelay; i++) begin
            nextCycle();
            if (stall && memReq && memAddr == {addr[31:2], 2'b00} && !rfWe) stallCycles++;
        end
        checkOutput({name, " stall cycles"}, stallCycles, ackDelay + 1);
        memAck   = 1'b1;
        memRdata = rdata;
        nextCycle();
        memAck   = 1'b0;
        memRdata = 32'h0;
        checkOutput({name, " rf_we"}, {31'b0, rfWe}, {31'b0, expWe});
        if (expWe) begin
            checkOutput({name, " rf_windex"}, {27'b0, rfWindex}, {27'b0, rd});
            checkOutput({name, " rf_wdata"}, rfWdata, expData);
        end
        checkOutput({name, " released"}, {30'b0, stall, memReq}, 32'd0);
        nextCycle();
        checkOutput({name, " we pulse"}, {31'b0, rfWe}, 32'd0);
    endtask

    initial begin
        // name, en, valid, rd, sel, f3, alu, pc4, imm, expWe, expIdx, expData, expMis
        vecs[0]  = '{"alu rd5",    1, 1, 5'd5,  2'd0, 3'd0, 32'h0000_1234, 32'h0,         32'h0,         1, 5'd5,  32'h0000_1234, 0};
        vecs[1]  = '{"pc4 rd1",    1, 1, 5'd1,  2'd2, 3'd0, 32'h1111_1111, 32'h0000_0404, 32'h2222_2222, 1, 5'd1,  32'h0000_0404, 0};
        vecs[2]  = '{"imm rd31",   1, 1, 5'd31, 2'd3, 3'd0, 32'h1111_1111, 32'h3333_3333, 32'hABCD_E000, 1, 5'd31, 32'hABCD_E000, 0};
        vecs[3]  = '{"alu rd0",    1, 1, 5'd0,  2'd0, 3'd0, 32'h0000_DEAD, 32'h0,         32'h0,         0, 5'd0,  32'h0000_DEAD, 0};
        vecs[4]  = '{"en low",     0, 1, 5'd9,  2'd0, 3'd0, 32'h5555_5555, 32'h0,         32'h0,         0, 5'd0,  32'h0,         0};
        vecs[5]  = '{"no valid",   1, 0, 5'd9,  2'd0, 3'd0, 32'h5555_5555, 32'h0,         32'h0,         0, 5'd0,  32'h0,         0};
        vecs[6]  = '{"mis lw",     1, 1, 5'd4,  2'd1, 3'b010, 32'h0000_0101, 32'h0,       32'h0,         0, 5'd0,  32'h0,         1};
        vecs[7]  = '{"mis lh",     1, 1, 5'd4,  2'd1, 3'b001, 32'h0000_0203, 32'h0,       32'h0,         0, 5'd0,  32'h0,         1};
        vecs[8]  = '{"mis lhu",    1, 1, 5'd4,  2'd1, 3'b101, 32'h0000_0201, 32'h0,       32'h0,         0, 5'd0,  32'h0,         1};
        vecs[9]  = '{"mis f3=011", 1, 1, 5'd4,  2'd1, 3'b011, 32'h0000_0102, 32'h0,       32'h0,         0, 5'd0,  32'h0,         1};
        vecs[10] = '{"load en0",   0, 1, 5'd4,  2'd1, 3'b010, 32'h0000_0100, 32'h0,       32'h0,         0, 5'd0,  32'h0,         0};

        nRST     = 1'b1;
        memAck   = 1'b0;
        memRdata = 32'h0;
        idleInputs();
        nextCycle();
        nextCycle();
        nRST = 1'b0;
        checkOutput("reset outputs",
                    {25'b0, memReq, stall, rfWe, misalignErr, 3'b0} | memAddr | {27'b0, rfWindex} | rfWdata,
                    32'd0);

        // Table vectors: one-cycle request, check next cycle, then pulse end.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].rd, vecs[i].sel, vecs[i].f3,
                          vecs[i].alu, vecs[i].pc4, vecs[i].imm);
            nextCycle();
            idleInputs();
            checkOutput({vecs[i].name, " rf_we"}, {31'b0, rfWe}, {31'b0, vecs[i].expWe});
            checkOutput({vecs[i].name, " rf_windex"}, {27'b0, rfWindex}, {27'b0, vecs[i].expIdx});
            checkOutput({vecs[i].name, " rf_wdata"}, rfWdata, vecs[i].expData);
            checkOutput({vecs[i].name, " misalign"}, {31'b0, misalignErr}, {31'b0, vecs[i].expMis});
            checkOutput({vecs[i].name, " no req"}, {30'b0, memReq, stall}, 32'd0);
            nextCycle();
            checkOutput({vecs[i].name, " pulse end"}, {30'b0, rfWe, misalignErr}, 32'd0);
        end

        // Load handshakes.
        runLoad("lb sign",  3'b000, 32'h0000_0103, 5'd7,  3, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80);
        runLoad("lhu",      3'b101, 32'h0000_0202, 5'd3,  1, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF);
        runLoad("lhu rd0",  3'b101, 32'h0000_0202, 5'd0,  2, 32'hBEEF_0000, 1'b0, 32'h0000_BEEF);
        runLoad("lh sign",  3'b001, 32'h0000_0200, 5'd10, 0, 32'h1234_8001, 1'b1, 32'hFFFF_8001);
        runLoad("lbu",      3'b100, 32'h0000_0101, 5'd11, 1, 32'h0000_C300, 1'b1, 32'h0000_00C3);
        runLoad("lw",       3'b010, 32'h0000_0300, 5'd12, 2, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
        runLoad("lb pos",   3'b000, 32'h0000_0100, 5'd13, 0, 32'h0000_007F, 1'b1, 32'h0000_007F);

        // Back-to-back: ALU write then load issue on the next cycle.
        applyStimulus(1'b1, 1'b1, 5'd2, 2'd0, 3'd0, 32'h0000_0055, 32'h0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd6, 2'd1, 3'b010, 32'h0000_0400, 32'h0, 32'h0);
        checkOutput("b2b alu we", {27'b0, rfWe, rfWindex}, {27'b0, 1'b1, 5'd2});
        nextCycle();
        idleInputs();
        checkOutput("b2b load req", {30'b0, memReq, stall}, 32'd3);
        checkOutput("b2b alu pulse", {31'b0, rfWe}, 32'd0);
        memAck   = 1'b1;
        memRdata = 32'h0BAD_F00D;
        nextCycle();
        memAck   = 1'b0;
        checkOutput("b2b load data", rfWdata, 32'h0BAD_F00D);
        checkOutput("b2b load idx", {26'b0, rfWe, rfWindex}, {26'b0, 1'b1, 5'd6});
        nextCycle();

        // Reset during LOAD_WAIT, then a late ack.
        applyStimulus(1'b1, 1'b1, 5'd8, 2'd1, 3'b010, 32'h0000_0500, 32'h0, 32'h0);
        nextCycle();
        idleInputs();
        checkOutput("rst load req", {30'b0, memReq, stall}, 32'd3);
        nRST = 1'b1;
        nextCycle();
        nRST = 1'b0;
        checkOutput("rst released", {30'b0, memReq, stall}, 32'd0);
        nextCycle();
        memAck   = 1'b1;
        memRdata = 32'h1234_5678;
        nextCycle();
        memAck   = 1'b0;
        checkOutput("rst late ack", {29'b0, rfWe, memReq, stall}, 32'd0);
        nextCycle();
        checkOutput("rst late ack 2", {31'b0, rfWe}, 32'd0);

`ifdef WB_LOAD_TIMEOUT_EN
        // No ack: four wait cycles, then abort with the error strobe.
        applyStimulus(1'b1, 1'b1, 5'd9, 2'd1, 3'b010, 32'h0000_0600, 32'h0, 32'h0);
        nextCycle();
        idleInputs();
        for (int i = 1; i < 4; i++) begin
            checkOutput("tmo waiting", {30'b0, memReq, stall}, 32'd3);
            nextCycle();
        end
        checkOutput("tmo last wait", {30'b0, memReq, stall}, 32'd3);
        nextCycle();
        checkOutput("tmo abort", {28'b0, misalignErr, rfWe, memReq, stall}, 32'd8);
        nextCycle();
        checkOutput("tmo pulse end", {31'b0, misalignErr}, 32'd0);
`else
        // No timeout: the load waits as long as it takes.
        applyStimulus(1'b1, 1'b1, 5'd9, 2'd1, 3'b010, 32'h0000_0600, 32'h0, 32'h0);
        nextCycle();
        idleInputs();
        for (int i = 0; i < 10; i++) nextCycle();
        checkOutput("long wait held", {29'b0, misalignErr, memReq, stall}, 32'd3);
        memAck   = 1'b1;
        memRdata = 32'h0000_0099;
        nextCycle();
        memAck   = 1'b0;
        checkOutput("long wait data", rfWdata, 32'h0000_0099);
        nextCycle();
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
